// File: rtl/gpio_cfg_pkg.sv
// gpio_cfg_pkg: shared sizes, slot mapping, commit states and decoder opcodes for the tone bank
package gpio_cfg_pkg;
   localparam int NUM_CH   = 2;
   localparam int NUM_TONE = 8;
   localparam int NUM_SLOT = NUM_CH * NUM_TONE;
   localparam int SLOT_W   = $clog2(NUM_SLOT);
   typedef enum logic {IDLE, PEND} commit_state_t;
   localparam logic [3:0] OP_NOP    = 4'h0;
   localparam logic [3:0] OP_INDEX  = 4'h1;
   localparam logic [3:0] OP_GAIN   = 4'h2;
   localparam logic [3:0] OP_COMMIT = 4'h3;
   localparam logic [3:0] OP_SAFE   = 4'h4;
   function automatic logic [SLOT_W-1:0] slot_of(input logic ch, input logic [2:0] tone);
      return {ch, tone};
   endfunction
endpackage

// File: rtl/gpio_cfg_shadow_bank.sv
// gpio_cfg_shadow_bank: shadow index/gain storage with per-slot dirty mask
module gpio_cfg_shadow_bank
   import gpio_cfg_pkg::*;
#(
   parameter int IDX_W  = 10,
   parameter int GAIN_W = 18
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       idx_we,
   input  logic                       gain_we,
   input  logic [SLOT_W-1:0]          wr_slot,
   input  logic [IDX_W-1:0]           wr_index,
   input  logic [GAIN_W-1:0]          wr_gain,
   input  logic                       clr_dirty,
   output logic [NUM_SLOT*IDX_W-1:0]  sh_index,
   output logic [NUM_SLOT*GAIN_W-1:0] sh_gain,
   output logic [NUM_SLOT-1:0]        dirty
);
   // a write in the clearing cycle wins, so that slot stays dirty
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_index <= '0;
         sh_gain  <= '0;
         dirty    <= '0;
      end else begin
         for (int i = 0; i < NUM_SLOT; i++) begin
            if (idx_we && wr_slot == SLOT_W'(i)) sh_index[i*IDX_W +: IDX_W] <= wr_index;
            if (gain_we && wr_slot == SLOT_W'(i)) sh_gain[i*GAIN_W +: GAIN_W] <= wr_gain;
            dirty[i] <= ((idx_we || gain_we) && wr_slot == SLOT_W'(i)) || (dirty[i] && !clr_dirty);
         end
      end
   end
endmodule

// File: rtl/gpio_cfg_tone_bank.sv
// gpio_cfg_tone_bank: shadow/active tone bank with safe-gated, frame-aligned atomic commit
module gpio_cfg_tone_bank
   import gpio_cfg_pkg::*;
#(
   parameter int IDX_W      = 10,
   parameter int GAIN_W     = 18,
   parameter bit FRAME_SYNC = 1'b1,
   parameter bit SAFE_RST   = 1'b0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       idx_we,
   input  logic                       gain_we,
   input  logic                       wr_ch,
   input  logic [2:0]                 wr_tone,
   input  logic [IDX_W-1:0]           wr_index,
   input  logic [GAIN_W-1:0]          wr_gain,
   input  logic                       commit_req,
   input  logic                       safe_we,
   input  logic                       safe_val,
   input  logic                       frame_tick,
   output logic [NUM_SLOT*IDX_W-1:0]  act_index,
   output logic [NUM_SLOT*GAIN_W-1:0] act_gain,
   output logic [NUM_SLOT-1:0]        dirty,
   output logic                       safe_en,
   output logic                       busy,
   output logic                       commit_done,
   output logic                       commit_rej,
   output logic [15:0]                commit_cnt,
   output logic [15:0]                rej_cnt
);
   commit_state_t state, state_nxt;
   logic [NUM_SLOT*IDX_W-1:0]  sh_index;
   logic [NUM_SLOT*GAIN_W-1:0] sh_gain;
   logic apply, cancel, reject;

   gpio_cfg_shadow_bank #(.IDX_W(IDX_W), .GAIN_W(GAIN_W)) u_shadow (
      .clk       (clk),
      .rst_n     (rst_n),
      .idx_we    (idx_we),
      .gain_we   (gain_we),
      .wr_slot   (slot_of(wr_ch, wr_tone)),
      .wr_index  (wr_index),
      .wr_gain   (wr_gain),
      .clr_dirty (apply),
      .sh_index  (sh_index),
      .sh_gain   (sh_gain),
      .dirty     (dirty)
   );

   // a cancel beats an apply arriving in the same cycle
   always_comb begin
      cancel    = state == PEND && safe_we && !safe_val;
      apply     = state == PEND && !cancel && (!FRAME_SYNC || frame_tick);
      reject    = cancel || (state == IDLE && commit_req && !safe_en);
      state_nxt = state == IDLE ? ((commit_req && safe_en) ? PEND : IDLE)
                                : ((apply || cancel) ? IDLE : PEND);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   assign busy = state == PEND;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_index   <= '0;
         act_gain    <= '0;
         safe_en     <= SAFE_RST;
         commit_done <= 1'b0;
         commit_rej  <= 1'b0;
         commit_cnt  <= '0;
         rej_cnt     <= '0;
      end else begin
         act_index   <= apply ? sh_index : act_index;
         act_gain    <= apply ? sh_gain : act_gain;
         safe_en     <= safe_we ? safe_val : safe_en;
         commit_done <= apply;
         commit_rej  <= reject;
         commit_cnt  <= commit_cnt + 16'(apply);
         rej_cnt     <= rej_cnt + 16'(reject && rej_cnt != 16'hFFFF);
      end
   end
endmodule

// File: tb/tb_gpio_cfg_tone_bank.sv
// tb_gpio_cfg_tone_bank: directed table, corner sequences and random run against an array model
module tb_gpio_cfg_tone_bank;
   localparam int IW = 10;
   localparam int GW = 18;

   typedef struct {
      bit iw, gw, ch;
      bit [2:0] tn;
      bit [9:0] ix;
      bit [17:0] gn;
      bit cr, sw, sv, ft;
      bit [15:0] e_dirty;
      bit e_busy, e_done, e_rej;
      bit [15:0] e_cnt, e_rcnt;
   } vec_t;

   logic clk = 1'b0, rst_n = 1'b0;
   logic idx_we = 0, gain_we = 0, wr_ch = 0, commit_req = 0, safe_we = 0, safe_val = 0, frame_tick = 0;
   logic [2:0] wr_tone = '0;
   logic [IW-1:0] wr_index = '0;
   logic [GW-1:0] wr_gain = '0;
   logic [16*IW-1:0] ai[2];
   logic [16*GW-1:0] ag[2];
   logic [15:0] dt[2], cc[2], rc[2];
   logic se[2], bz[2], dn[2], rj[2];

   int n_chk = 0, n_fail = 0;

   int unsigned m_si[2][16], m_sg[2][16], m_ai[2][16], m_ag[2][16], m_cc[2], m_rc[2];
   bit m_dt[2][16];
   bit m_safe[2], m_pend[2], m_done[2], m_rej[2];

   always #5 clk = ~clk;

   gpio_cfg_tone_bank #(.IDX_W(IW), .GAIN_W(GW), .FRAME_SYNC(1'b1), .SAFE_RST(1'b0)) u_sync (
      .clk(clk), .rst_n(rst_n), .idx_we(idx_we), .gain_we(gain_we), .wr_ch(wr_ch), .wr_tone(wr_tone),
      .wr_index(wr_index), .wr_gain(wr_gain), .commit_req(commit_req), .safe_we(safe_we),
      .safe_val(safe_val), .frame_tick(frame_tick), .act_index(ai[0]), .act_gain(ag[0]),
      .dirty(dt[0]), .safe_en(se[0]), .busy(bz[0]), .commit_done(dn[0]), .commit_rej(rj[0]),
      .commit_cnt(cc[0]), .rej_cnt(rc[0]));

   gpio_cfg_tone_bank #(.IDX_W(IW), .GAIN_W(GW), .FRAME_SYNC(1'b0), .SAFE_RST(1'b0)) u_imm (
      .clk(clk), .rst_n(rst_n), .idx_we(idx_we), .gain_we(gain_we), .wr_ch(wr_ch), .wr_tone(wr_tone),
      .wr_index(wr_index), .wr_gain(wr_gain), .commit_req(commit_req), .safe_we(safe_we),
      .safe_val(safe_val), .frame_tick(frame_tick), .act_index(ai[1]), .act_gain(ag[1]),
      .dirty(dt[1]), .safe_en(se[1]), .busy(bz[1]), .commit_done(dn[1]), .commit_rej(rj[1]),
      .commit_cnt(cc[1]), .rej_cnt(rc[1]));

   task automatic chk(input string nm, input logic [287:0] got, input logic [287:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         for (int k = 0; k < 16; k++) begin
            m_si[m][k] = 0; m_sg[m][k] = 0; m_ai[m][k] = 0; m_ag[m][k] = 0; m_dt[m][k] = 0;
         end
         m_safe[m] = 0; m_pend[m] = 0; m_done[m] = 0; m_rej[m] = 0; m_cc[m] = 0; m_rc[m] = 0;
      end
   endtask

   // model 0 waits for frame_tick, model 1 applies on the first pending cycle
   task automatic model_step();
      int s;
      bit ap, cn;
      s = int'(wr_ch) * 8 + int'(wr_tone);
      for (int m = 0; m < 2; m++) begin
         cn = m_pend[m] && safe_we && !safe_val;
         ap = m_pend[m] && !cn && (m == 1 || frame_tick);
         m_done[m] = ap;
         m_rej[m] = cn || (!m_pend[m] && commit_req && !m_safe[m]);
         if (ap) begin
            for (int k = 0; k < 16; k++) begin
               m_ai[m][k] = m_si[m][k]; m_ag[m][k] = m_sg[m][k]; m_dt[m][k] = 0;
            end
            m_cc[m] = (m_cc[m] + 1) % 65536;
         end
         if (m_rej[m] && m_rc[m] < 65535) m_rc[m]++;
         m_pend[m] = m_pend[m] ? !(ap || cn) : (commit_req && m_safe[m]);
         if (safe_we) m_safe[m] = safe_val;
         if (idx_we) begin m_si[m][s] = wr_index; m_dt[m][s] = 1; end
         if (gain_we) begin m_sg[m][s] = wr_gain; m_dt[m][s] = 1; end
      end
   endtask

   task automatic check_model();
      logic [16*IW-1:0] ei;
      logic [16*GW-1:0] eg;
      logic [15:0] ed;
      for (int m = 0; m < 2; m++) begin
         for (int k = 0; k < 16; k++) begin
            ei[k*IW +: IW] = IW'(m_si[m][k] * 0 + m_ai[m][k]);
            eg[k*GW +: GW] = GW'(m_ag[m][k]);
            ed[k] = m_dt[m][k];
         end
         chk($sformatf("dut%0d act_index", m), 288'(ai[m]), 288'(ei));
         chk($sformatf("dut%0d act_gain", m), 288'(ag[m]), 288'(eg));
         chk($sformatf("dut%0d dirty", m), 288'(dt[m]), 288'(ed));
         chk($sformatf("dut%0d safe_en", m), 288'(se[m]), 288'(m_safe[m]));
         chk($sformatf("dut%0d busy", m), 288'(bz[m]), 288'(m_pend[m]));
         chk($sformatf("dut%0d commit_done", m), 288'(dn[m]), 288'(m_done[m]));
         chk($sformatf("dut%0d commit_rej", m), 288'(rj[m]), 288'(m_rej[m]));
         chk($sformatf("dut%0d commit_cnt", m), 288'(cc[m]), 288'(m_cc[m]));
         chk($sformatf("dut%0d rej_cnt", m), 288'(rc[m]), 288'(m_rc[m]));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_step();
      #1;
      check_model();
      idx_we = 0; gain_we = 0; commit_req = 0; safe_we = 0; safe_val = 0; frame_tick = 0;
   endtask

   task automatic chk_reset_values(input string tag);
      for (int m = 0; m < 2; m++) begin
         chk($sformatf("%s dut%0d act_index", tag, m), 288'(ai[m]), 288'(0));
         chk($sformatf("%s dut%0d act_gain", tag, m), 288'(ag[m]), 288'(0));
         chk($sformatf("%s dut%0d dirty", tag, m), 288'(dt[m]), 288'(0));
         chk($sformatf("%s dut%0d safe_en", tag, m), 288'(se[m]), 288'(0));
         chk($sformatf("%s dut%0d busy", tag, m), 288'(bz[m]), 288'(0));
         chk($sformatf("%s dut%0d commit_done", tag, m), 288'(dn[m]), 288'(0));
         chk($sformatf("%s dut%0d commit_rej", tag, m), 288'(rj[m]), 288'(0));
         chk($sformatf("%s dut%0d commit_cnt", tag, m), 288'(cc[m]), 288'(0));
         chk($sformatf("%s dut%0d rej_cnt", tag, m), 288'(rc[m]), 288'(0));
      end
   endtask

   function automatic vec_t mk(bit iw, bit gw, bit ch, bit [2:0] tn, bit [9:0] ix, bit [17:0] gn,
                               bit cr, bit sw, bit sv, bit ft, bit [15:0] d, bit b, bit dne, bit rje,
                               bit [15:0] c, bit [15:0] r);
      vec_t v;
      v.iw = iw; v.gw = gw; v.ch = ch; v.tn = tn; v.ix = ix; v.gn = gn;
      v.cr = cr; v.sw = sw; v.sv = sv; v.ft = ft;
      v.e_dirty = d; v.e_busy = b; v.e_done = dne; v.e_rej = rje; v.e_cnt = c; v.e_rcnt = r;
      return v;
   endfunction

   vec_t tbl[$];

   initial begin
      tbl.push_back(mk(1,0,1,5,10'h155,0,       0,0,0,0, 16'h2000,0,0,0,0,0));
      tbl.push_back(mk(0,0,0,0,0,0,             1,0,0,0, 16'h2000,0,0,1,0,1));
      tbl.push_back(mk(0,0,0,0,0,0,             0,0,0,0, 16'h2000,0,0,0,0,1));
      tbl.push_back(mk(0,1,0,2,0,18'h1FFFF,     0,1,1,0, 16'h2004,0,0,0,0,1));
      tbl.push_back(mk(0,0,0,0,0,0,             1,0,0,0, 16'h2004,1,0,0,0,1));
      for (int i = 0; i < 9; i++)
         tbl.push_back(mk(0,0,0,0,0,0,          0,0,0,0, 16'h2004,1,0,0,0,1));
      tbl.push_back(mk(0,0,0,0,0,0,             0,0,0,1, 16'h0000,0,1,0,1,1));
      tbl.push_back(mk(0,0,0,0,0,0,             0,0,0,0, 16'h0000,0,0,0,1,1));
      tbl.push_back(mk(0,0,0,0,0,0,             1,0,0,0, 16'h0000,1,0,0,1,1));
      tbl.push_back(mk(0,0,0,0,0,0,             1,1,0,0, 16'h0000,0,0,1,1,2));
      tbl.push_back(mk(0,0,0,0,0,0,             0,0,0,1, 16'h0000,0,0,0,1,2));
      tbl.push_back(mk(0,0,0,0,0,0,             0,1,1,0, 16'h0000,0,0,0,1,2));
      tbl.push_back(mk(0,0,0,0,0,0,             1,0,0,0, 16'h0000,1,0,0,1,2));
      tbl.push_back(mk(1,0,0,0,10'h3FF,0,       0,0,0,1, 16'h0001,0,1,0,2,2));
      tbl.push_back(mk(0,0,0,0,0,0,             0,0,0,0, 16'h0001,0,0,0,2,2));

      model_reset();
      #12;
      chk_reset_values("reset");
      rst_n = 1;

      foreach (tbl[i]) begin
         idx_we = tbl[i].iw; gain_we = tbl[i].gw; wr_ch = tbl[i].ch; wr_tone = tbl[i].tn;
         wr_index = tbl[i].ix; wr_gain = tbl[i].gn; commit_req = tbl[i].cr;
         safe_we = tbl[i].sw; safe_val = tbl[i].sv; frame_tick = tbl[i].ft;
         tick();
         chk($sformatf("row%0d dirty", i), 288'(dt[0]), 288'(tbl[i].e_dirty));
         chk($sformatf("row%0d busy", i), 288'(bz[0]), 288'(tbl[i].e_busy));
         chk($sformatf("row%0d commit_done", i), 288'(dn[0]), 288'(tbl[i].e_done));
         chk($sformatf("row%0d commit_rej", i), 288'(rj[0]), 288'(tbl[i].e_rej));
         chk($sformatf("row%0d commit_cnt", i), 288'(cc[0]), 288'(tbl[i].e_cnt));
         chk($sformatf("row%0d rej_cnt", i), 288'(rc[0]), 288'(tbl[i].e_rcnt));
         if (i == 0) chk("row0 act_index slot13", 288'(ai[0][13*IW +: IW]), 288'(0));
      end
      chk("act_index slot0 pre-write", 288'(ai[0][0 +: IW]), 288'(0));
      chk("act_index slot13", 288'(ai[0][13*IW +: IW]), 288'(10'h155));
      chk("act_gain slot2", 288'(ag[0][2*GW +: GW]), 288'(18'h1FFFF));

      // immediate build: write at n, commit at n+1, visible at n+3
      idx_we = 1; wr_ch = 0; wr_tone = 7; wr_index = 10'h2AA;
      tick();
      commit_req = 1;
      tick();
      chk("imm done early", 288'(dn[1]), 288'(0));
      tick();
      chk("imm commit_done", 288'(dn[1]), 288'(1));
      chk("imm act_index slot7", 288'(ai[1][7*IW +: IW]), 288'(10'h2AA));
      chk("sync still pending", 288'(bz[0]), 288'(1));

      #2 rst_n = 0;
      #1;
      chk_reset_values("mid-pend reset");
      model_reset();
      tick();
      rst_n = 1;
      tick();
      tick();
      chk("post-reset no done", 288'(dn[0]), 288'(0));
      chk("post-reset no rej", 288'(rj[0]), 288'(0));

      for (int c = 0; c < 3000; c++) begin
         idx_we = ($urandom % 4) == 0;
         gain_we = ($urandom % 4) == 0;
         wr_ch = 1'($urandom);
         wr_tone = 3'($urandom);
         wr_index = IW'($urandom);
         wr_gain = GW'($urandom);
         commit_req = ($urandom % 6) == 0;
         safe_we = ($urandom % 10) == 0;
         safe_val = ($urandom % 4) != 0;
         frame_tick = ($urandom % 8) == 0;
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/gpio_cfg_tone_bank.md
Name: gpio_cfg_tone_bank

Overview:
- Sits directly downstream of the 32-bit AXI-Stream command decoder.
- Consumes its single-cycle write pulses (index, gain, commit, safe) into a shadow register bank of 2 channels x 8 tones.
- On an accepted commit, copies the whole shadow bank atomically into the active bank at the next frame boundary.
- The active bank drives the DDS tone generators, so they never see a partially updated set.

Parameters:
- IDX_W, 10, tone index (frequency word) width.
- GAIN_W, 18, tone gain width (Q1.17).
- FRAME_SYNC, 1, 1 = apply commit on frame_tick; 0 = apply on the cycle after acceptance.
- SAFE_RST, 0, reset value of the safe (commit-enable) flag.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- idx_we  in  1  write shadow index (1-cycle pulse)
- gain_we  in  1  write shadow gain (1-cycle pulse)
- wr_ch  in  1  target channel, 0=A, 1=B
- wr_tone  in  3  target tone, 0..7
- wr_index  in  IDX_W  index payload
- wr_gain  in  GAIN_W  gain payload
- commit_req  in  1  commit request pulse
- safe_we  in  1  safe-flag write pulse
- safe_val  in  1  1 = commits allowed, 0 = blocked
- frame_tick  in  1  DDS frame boundary strobe, 1 cycle
- act_index  out  16*IDX_W  active indices; slot s = ch*8+tone occupies bits [s*IDX_W +: IDX_W]
- act_gain  out  16*GAIN_W  active gains, same packing
- dirty  out  16  per-slot "shadow differs from active since last apply"
- safe_en  out  1  current safe flag
- busy  out  1  commit pending (state != IDLE)
- commit_done  out  1  1-cycle pulse: active bank just updated
- commit_rej  out  1  1-cycle pulse: commit refused or cancelled
- commit_cnt  out  16  applied commits, wraps
- rej_cnt  out  16  rejected/cancelled commits, saturates at 0xFFFF

Behaviour:
Reset (async, rst_n low):
- All shadow and active index/gain = 0 (gain 0 = muted).
- dirty = 0; safe_en = SAFE_RST; state = IDLE.
- commit_done, commit_rej, commit_cnt, rej_cnt = 0.
- Reset mid-PEND drops the pending commit silently; no pulses.

Shadow writes:
- idx_we and gain_we are independent; both may be high in the same cycle.
- On the edge sampling idx_we/gain_we, shadow[slot] is written and dirty[slot] is set.

Safe flag:
- safe_we loads safe_en <= safe_val on the next edge.

Commit state machine (IDLE, PEND):
- IDLE + commit_req + safe_en=1 -> PEND. busy=1 from the next cycle.
- IDLE + commit_req + safe_en=0 -> stay IDLE; commit_rej pulses next cycle; rej_cnt++.
- safe_en is the value registered before this edge: a safe_we in the same cycle as commit_req does not affect that commit.
- PEND + (FRAME_SYNC=0, or frame_tick=1) -> apply, -> IDLE.
- frame_tick in the same cycle as the commit_req that enters PEND is ignored; the apply waits for the next tick.
- PEND + commit_req -> coalesced: no extra apply, no count.
- PEND + safe_we with safe_val=0 -> cancel, -> IDLE; commit_rej pulse; rej_cnt++. This takes priority over a simultaneous apply condition.

Apply edge:
- All 16 active slots load from shadow.
- dirty is cleared, except slots written by idx_we/gain_we in that same cycle. Those get the new shadow value and keep dirty=1; active receives the pre-write shadow value.
- Apply latency: FRAME_SYNC=0 -> new act_* visible 2 cycles after the commit_req cycle.
- commit_done is high in the first cycle the new act_* values are visible; commit_cnt increments on the same edge.

Outputs:
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package gpio_cfg_pkg:
  - NUM_CH=2, NUM_TONE=8, NUM_SLOT=16.
  - slot_of(ch, tone) function.
  - Commit state enum {IDLE, PEND}.
  - Command opcode constants, already shared with the decoder.
- One sub-module, gpio_cfg_shadow_bank: shadow index/gain storage plus dirty mask, with write port and clear-on-apply input.
- The commit FSM, counters and active registers stay in the top.

Test Plan:
- Reset, then idx_we ch=1 tone=5 wr_index=0x155 -> dirty=0x2000; act_index slot 13 remains 0; busy=0.
- safe_en=0 (reset), commit_req -> commit_rej pulse; rej_cnt=1; act_* unchanged; busy stays 0.
- safe_we val=1, gain_we ch=0 tone=2 gain=0x1FFFF, commit_req, frame_tick 10 cycles later -> busy for 10 cycles; commit_done 1 cycle after the tick; act_gain slot 2 = 0x1FFFF; dirty=0; commit_cnt=1.
- In PEND: second commit_req plus safe_we val=0 -> commit_rej; busy=0; act_* unchanged; commit_cnt unchanged; a later frame_tick does nothing.
- idx_we slot 0 = 0x3FF coincident with the apply edge -> act_index slot 0 = old shadow value; shadow = 0x3FF; dirty[0]=1.
- FRAME_SYNC=0 build: idx_we at cycle n, commit_req at n+1 -> act_index updated and commit_done high at n+3. Also: assert rst_n mid-PEND -> all outputs at reset values, no pulses.
